// File: rtl/unittest_monitor.sv
// rtl/unittest_monitor.sv - bus-snooping console, test-result and watchdog peripheral
module unittest_monitor #(
    parameter logic [31:0] CONSOLE_ADDR   = 32'h1000_0000,
    parameter logic [31:0] RESULT_ADDR    = 32'h1000_0010,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int          FINISH_ON_DONE = 1,
    parameter int          SIM_PRINT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_ready,
    output logic        char_valid,
    output logic [7:0]  char_data,
    output logic [31:0] char_count,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout
);

    // A zero limit turns the watchdog off; the wrapped compare value is then never used.
    localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic        ready_q, ready_d;
    logic        char_valid_q, char_valid_d;
    logic [7:0]  char_data_q, char_data_d;
    logic [31:0] char_count_q, char_count_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [30:0] fail_code_q, fail_code_d;
    logic        timeout_q, timeout_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;

    logic        result_match, console_match;
    logic        result_hit, console_hit, result_accept;
    logic        wd_running, wd_expire;
    logic [7:0]  lane_byte;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^dmem_addr[1:0];

    // Decode writes to our two words; the result register wins if both addresses coincide.
    always_comb begin
        result_match  = (dmem_addr[31:2] == RESULT_ADDR[31:2]);
        console_match = (dmem_addr[31:2] == CONSOLE_ADDR[31:2]);
        result_hit    = (dmem_wmask != 4'b0000) && result_match && !ready_q;
        console_hit   = (dmem_wmask != 4'b0000) && console_match && !result_match && !ready_q;
        result_accept = result_hit && !done_q;
    end

    // Console byte comes from the lowest enabled write lane.
    always_comb begin
        lane_byte = dmem_wdata[31:24];
        if (dmem_wmask[0])      lane_byte = dmem_wdata[7:0];
        else if (dmem_wmask[1]) lane_byte = dmem_wdata[15:8];
        else if (dmem_wmask[2]) lane_byte = dmem_wdata[23:16];
    end

    // Next-state for handshake, console, result latch and watchdog.
    always_comb begin
        ready_d      = result_hit || console_hit;
        char_valid_d = console_hit;
        char_data_d  = char_data_q;
        char_count_d = char_count_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_code_d  = fail_code_q;
        wd_cnt_d     = wd_cnt_q;

        if (console_hit) begin
            char_data_d  = lane_byte;
            char_count_d = char_count_q + 32'd1;
        end

        // First result written after reset is the one that sticks.
        if (result_accept) begin
            done_d      = 1'b1;
            pass_d      = (dmem_wdata == 32'd1);
            fail_code_d = (dmem_wdata == 32'd1) ? 31'd0 : dmem_wdata[31:1];
        end

        wd_running = !done_q && !timeout_q;
        wd_expire  = WD_EN && wd_running && (wd_cnt_q == WD_LAST);
        if (wd_running) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
        end
        // A result landing on the expiry cycle means the test finished in time.
        timeout_d = timeout_q || (wd_expire && !result_accept);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q      <= 1'b0;
            char_valid_q <= 1'b0;
            char_data_q  <= 8'd0;
            char_count_q <= 32'd0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_code_q  <= 31'd0;
            timeout_q    <= 1'b0;
            wd_cnt_q     <= 32'd0;
        end else begin
            ready_q      <= ready_d;
            char_valid_q <= char_valid_d;
            char_data_q  <= char_data_d;
            char_count_q <= char_count_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_code_q  <= fail_code_d;
            timeout_q    <= timeout_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign dmem_ready = ready_q;
    assign char_valid = char_valid_q;
    assign char_data  = char_data_q;
    assign char_count = char_count_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_code  = fail_code_q;
    assign timeout    = timeout_q;

`ifndef SYNTHESIS
    logic finish_arm_q;

    // Simulation-only console echo, result report and end-of-test stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            finish_arm_q <= 1'b0;
        end else begin
            finish_arm_q <= done_q || timeout_q;
            if (SIM_PRINT != 0 && console_hit) begin
                $write("%c", lane_byte);
            end
            if (SIM_PRINT != 0 && result_accept) begin
                if (dmem_wdata == 32'd1) $write("PASS\n");
                else                     $write("FAIL %0d\n", dmem_wdata[31:1]);
            end
            if (FINISH_ON_DONE != 0 && finish_arm_q) begin
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unittest_monitor.sv
// tb/tb_unittest_monitor.sv - randomized self-checking bench for unittest_monitor
module tb_unittest_monitor;

    localparam logic [31:0] CON = 32'h1000_0000;
    localparam logic [31:0] RES = 32'h1000_0010;

    typedef struct {
        bit        rdy;
        bit        vld;
        bit [7:0]  chr;
        bit [31:0] cnt;
        bit        dn;
        bit        ps;
        bit [30:0] code;
        bit        tmo;
        longint    cyc;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic [31:0] addr, addr2, wdata, wdata2;
    logic [3:0]  wmask, wmask2;
    logic        rdy, cv, dn, ps, to, rdy2, cv2, dn2, ps2, to2;
    logic [7:0]  cd, cd2;
    logic [31:0] cc, cc2;
    logic [30:0] fc, fc2;

    int n_cmp = 0;
    int n_fail = 0;
    mstate_t m, m2;

    always #5 clk = ~clk;

    unittest_monitor #(.TIMEOUT_CYCLES(1_000_000), .FINISH_ON_DONE(0), .SIM_PRINT(0)) dut (
        .clk(clk), .reset(rst), .dmem_addr(addr), .dmem_wmask(wmask), .dmem_wdata(wdata),
        .dmem_ready(rdy), .char_valid(cv), .char_data(cd), .char_count(cc),
        .done(dn), .pass(ps), .fail_code(fc), .timeout(to));

    unittest_monitor #(.TIMEOUT_CYCLES(20), .FINISH_ON_DONE(0), .SIM_PRINT(0)) dut_wd (
        .clk(clk), .reset(rst2), .dmem_addr(addr2), .dmem_wmask(wmask2), .dmem_wdata(wdata2),
        .dmem_ready(rdy2), .char_valid(cv2), .char_data(cd2), .char_count(cc2),
        .done(dn2), .pass(ps2), .fail_code(fc2), .timeout(to2));

    // Behavioural model: what the peripheral should show after one clock edge.
    function automatic mstate_t model_next(mstate_t s, bit r, bit [31:0] a, bit [3:0] wm,
                                           bit [31:0] d, int unsigned tlim);
        mstate_t n;
        bit is_res, is_con;
        int lane;
        n = s;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        is_res = (wm != 0) && (a[31:2] == RES[31:2]) && !s.rdy;
        is_con = (wm != 0) && (a[31:2] == CON[31:2]) && !s.rdy && !is_res;
        n.rdy = is_res || is_con;
        n.vld = is_con;
        if (is_con) begin
            lane  = wm[0] ? 0 : wm[1] ? 1 : wm[2] ? 2 : 3;
            n.chr = 8'(d >> (8 * lane));
            n.cnt = s.cnt + 1;
        end
        if (is_res && !s.dn) begin
            n.dn   = 1;
            n.ps   = (d == 1);
            n.code = (d == 1) ? 31'd0 : d[31:1];
        end
        if (!s.dn && !s.tmo) begin
            n.cyc = s.cyc + 1;
            if (tlim != 0 && n.cyc == longint'(tlim) && !n.dn) n.tmo = 1;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        m  = model_next(m,  rst,  addr,  wmask,  wdata,  1_000_000);
        m2 = model_next(m2, rst2, addr2, wmask2, wdata2, 20);
        #1;
    endtask

    task automatic bus_idle();
        addr = 32'd0; wmask = 4'd0; wdata = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr = CON; wmask = 4'b0001; wdata = 32'h41;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({rdy, cv, cd, cc, dn, ps, fc, to} !== 76'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i,
                         {rdy, cv, cd, cc, dn, ps, fc, to});
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({rdy, cv, cd} !== {1'b1, 1'b1, 8'h41}) begin
            n_fail++;
            $display("FAIL reset_release_ack: got rdy=%b cv=%b cd=%h expected 1 1 41", rdy, cv, cd);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_console_hold();
        do_reset();
        addr = CON; wmask = 4'b0001; wdata = 32'h41;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({rdy, cv} !== {2{(i % 2) == 0}}) begin
                n_fail++;
                $display("FAIL hold_pulse cycle %0d: got rdy=%b cv=%b expected %b", i, rdy, cv, (i % 2) == 0);
            end
        end
        bus_idle();
        tick();
        n_cmp++;
        if ({cd, cc, cv} !== {8'h41, 32'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_result: got cd=%h cc=%0d cv=%b expected 41 2 0", cd, cc, cv);
        end
    endtask

    task automatic test_lane_and_read();
        addr = CON + 32'd2; wmask = 4'b0100; wdata = 32'h005A_0000;
        tick();
        n_cmp++;
        if ({rdy, cd, cc} !== {1'b1, 8'h5A, 32'd3}) begin
            n_fail++;
            $display("FAIL lane2_byte: got rdy=%b cd=%h cc=%0d expected 1 5a 3", rdy, cd, cc);
        end
        wmask = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({rdy, cv, cc} !== {1'b0, 1'b0, 32'd3}) begin
                n_fail++;
                $display("FAIL read_ignored cycle %0d: got rdy=%b cv=%b cc=%0d expected 0 0 3", i, rdy, cv, cc);
            end
        end
    endtask

    task automatic test_result_pass();
        do_reset();
        addr = RES; wmask = 4'b1111; wdata = 32'd1;
        tick();
        bus_idle();
        tick();
        n_cmp++;
        if ({dn, ps, fc} !== {1'b1, 1'b1, 31'd0}) begin
            n_fail++;
            $display("FAIL result_pass: got dn=%b ps=%b fc=%0d expected 1 1 0", dn, ps, fc);
        end
        addr = RES; wmask = 4'b1111; wdata = 32'd7;
        tick();
        n_cmp++;
        if ({rdy, dn, ps, fc} !== {1'b1, 1'b1, 1'b1, 31'd0}) begin
            n_fail++;
            $display("FAIL result_first_wins: got rdy=%b dn=%b ps=%b fc=%0d expected 1 1 1 0", rdy, dn, ps, fc);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_result_fail();
        do_reset();
        addr = RES + 32'd1; wmask = 4'b0001; wdata = 32'h0000_000B;
        tick();
        bus_idle();
        tick();
        n_cmp++;
        if ({dn, ps, fc, to} !== {1'b1, 1'b0, 31'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL result_fail_code: got dn=%b ps=%b fc=%0d to=%b expected 1 0 5 0", dn, ps, fc, to);
        end
    endtask

    task automatic test_random();
        logic [75:0] got, exp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 11))
                    0, 1, 2, 3, 4, 5: addr = CON | 32'($urandom_range(0, 3));
                    6:                addr = RES | 32'($urandom_range(0, 3));
                    default:          addr = $urandom;
                endcase
                wmask = 4'($urandom_range(0, 15));
                wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            end
            tick();
            got = {rdy, cv, cd, cc, dn, ps, fc, to};
            exp = {m.rdy, m.vld, m.chr, m.cnt, m.dn, m.ps, m.code, m.tmo};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", i, got, exp);
            end
        end
        rst = 1'b0;
        bus_idle();
        tick();
    endtask

    task automatic test_timeout();
        int cycles;
        rst2 = 1'b1;
        tick();
        tick();
        rst2 = 1'b0;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cycles++;
            if (to2 === 1'b1) break;
        end
        n_cmp++;
        if (to2 !== 1'b1 || cycles != 20 || m2.tmo != 1'b1) begin
            n_fail++;
            $display("FAIL timeout_latency: got to=%b after %0d cycles expected 1 after 20", to2, cycles);
        end
        addr2 = RES; wmask2 = 4'b1111; wdata2 = 32'd3;
        tick();
        wmask2 = 4'd0;
        tick();
        n_cmp++;
        if ({dn2, ps2, fc2, to2} !== {1'b1, 1'b0, 31'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_then_result: got dn=%b ps=%b fc=%0d to=%b expected 1 0 1 1", dn2, ps2, fc2, to2);
        end
    endtask

    task automatic test_result_on_expiry();
        rst2 = 1'b1;
        wmask2 = 4'd0;
        tick();
        tick();
        rst2 = 1'b0;
        repeat (19) tick();
        n_cmp++;
        if (to2 !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_early: got to=%b expected 0 after 19 cycles", to2);
        end
        addr2 = RES; wmask2 = 4'b1111; wdata2 = 32'd1;
        tick();
        wmask2 = 4'd0;
        repeat (5) tick();
        n_cmp++;
        if ({dn2, ps2, to2} !== {1'b1, 1'b1, 1'b0} || {m2.dn, m2.ps, m2.tmo} != 3'b110) begin
            n_fail++;
            $display("FAIL done_beats_expiry: got dn=%b ps=%b to=%b expected 1 1 0", dn2, ps2, to2);
        end
    endtask

    initial begin
        m  = '{default: 0};
        m2 = '{default: 0};
        rst2 = 1'b1;
        addr2 = 32'd0; wmask2 = 4'd0; wdata2 = 32'd0;
        rst = 1'b1;
        bus_idle();
        test_reset();
        test_console_hold();
        test_lane_and_read();
        test_result_pass();
        test_result_fail();
        test_random();
        test_timeout();
        test_result_on_expiry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/unittest_monitor.md
Name: unittest_monitor

Overview:
Memory-mapped test-control and console peripheral that sits on the CPU data bus beside the BRAM in simulation and test SoCs. It snoops bus writes, acknowledges writes to its own addresses, and logs console characters. It records pass/fail results written by firmware and flags a watchdog timeout. Its ready output is OR-ed with the BRAM ready into the CPU's mem_ready.

Parameters:
CONSOLE_ADDR, 32'h1000_0000, word address of the console byte-output register.
RESULT_ADDR, 32'h1000_0010, word address of the test-result register.
TIMEOUT_CYCLES, 1_000_000, cycles after reset before timeout is flagged; 0 disables the watchdog.
FINISH_ON_DONE, 1, when 1, a simulation build calls $finish two cycles after done or timeout rises; synthesis ignores it.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
dmem_addr  in  32  bus byte address.
dmem_wmask  in  4  byte write strobes; nonzero means a write.
dmem_wdata  in  32  write data.
dmem_ready  out  1  one-cycle write acknowledge.
char_valid  out  1  one-cycle pulse when a console byte is emitted.
char_data  out  8  last emitted console byte.
char_count  out  32  number of console bytes emitted since reset.
done  out  1  sticky; a result has been written.
pass  out  1  sticky; the result written was 1.
fail_code  out  31  result[31:1] of a failing write (riscv-tests test number).
timeout  out  1  sticky; watchdog expired before done.

Behaviour:
- One clock clk; reset is synchronous and active-high. While reset is high, every output and internal counter is cleared to 0 on the clock edge. Reset asserted mid-operation clears all state, including the sticky flags, on the next edge.
- Address match compares dmem_addr[31:2] against the parameter address [31:2]. Byte offset bits are ignored.
- hit = (wmask != 0) and address matches CONSOLE_ADDR or RESULT_ADDR and dmem_ready == 0. Reads are never acknowledged; the BRAM or default logic serves them.
- dmem_ready is registered: it is high in the cycle after a hit, for exactly one cycle. Because hit requires ready == 0, a write held on the bus produces alternating ready pulses, one per two cycles. This matches the BRAM handshake. The CPU drops the request after ready.
- Console hit: the byte is selected by the lowest set wmask bit (lane 0 = wdata[7:0] … lane 3 = wdata[31:24]). In the same registered cycle as ready, char_data takes the byte, char_valid pulses for one cycle, and char_count increments, wrapping at 2^32. In simulation the byte is printed with $write.
- Result hit: uses the full 32-bit wdata regardless of the partial wmask.
  - If done is already 1, the write is acknowledged but ignored; the first result wins.
  - If wdata == 1: done=1, pass=1, fail_code=0.
  - Otherwise: done=1, pass=0, fail_code=wdata[31:1]. wdata == 0 counts as a fail with code 0.
  - In simulation, "PASS" or "FAIL <code>" is printed.
- Watchdog: a 32-bit cycle counter increments each non-reset cycle while done==0 and timeout==0. When it reaches TIMEOUT_CYCLES-1, timeout is set on the next edge.
  - If a result hit and expiry occur in the same cycle, done wins and timeout stays 0.
  - After done or timeout, the counter freezes.
- Simultaneous console and result matches cannot occur (distinct addresses). If both parameters are set equal, the result function takes priority.
- No combinational path from inputs to outputs.

Test Plan:
- Reset high 3 cycles with a console write on the bus -> all outputs 0, no ready. Release reset; the first write is acknowledged one cycle later.
- Write addr 0x1000_0000, wmask 4'b0001, wdata 0x41, held 4 cycles -> ready pulses in cycles 1 and 3. char_data=0x41, char_count=2, char_valid pulses with each ready.
- Write addr 0x1000_0002, wmask 4'b0100, wdata 0x00_5A_00_00 -> char_data=0x5A. A read (wmask 0) to the same address -> no ready, count unchanged.
- Write RESULT_ADDR wdata 1 -> done=1, pass=1, fail_code=0. A second write of 7 -> ready pulses, flags unchanged.
- After reset, write RESULT_ADDR wdata 0x0000_000B -> done=1, pass=0, fail_code=5.
- TIMEOUT_CYCLES=20, no writes -> timeout=1 exactly 20 cycles after reset release. A later result write still sets done, and timeout stays 1.
